// File: rtl/rx_frame_parser_if.sv
// Receive-side bundle for rx_frame_parser: XGMII-style input word
// plus the registered per-frame decode results.
`timescale 1ns/1ps
interface rx_frame_parser_if #(
  parameter int LANES = 8
) ();
  logic [8*LANES-1:0] rxd;
  logic [LANES-1:0]   rxc;
  logic               sof;
  logic               eof;
  logic [47:0]        da_addr;
  logic [47:0]        sa_addr;
  logic [15:0]        lt_data;
  logic               tagged_frame;
  logic               pause_frame;
  logic [15:0]        byte_count;
  logic [2:0]         term_lane;
  logic               frame_error;
  logic               short_frame;
  logic               preamble_err;
  logic               length_error;

  modport master (
    output rxd, rxc,
    input  sof, eof, da_addr, sa_addr, lt_data,
    input  tagged_frame, pause_frame, byte_count,
    input  term_lane, frame_error, short_frame,
    input  preamble_err, length_error
  );

  modport slave (
    input  rxd, rxc,
    output sof, eof, da_addr, sa_addr, lt_data,
    output tagged_frame, pause_frame, byte_count,
    output term_lane, frame_error, short_frame,
    output preamble_err, length_error
  );
endinterface

// File: rtl/rx_frame_parser.sv
// LANES-wide receive frame parser: start/SFD, header capture, counting.
// Optional macro RX_LEN_CHECK_EN enables the length/type comparator.
`timescale 1ns/1ps
module rx_frame_parser #(
  parameter int         LANES      = 8,
  parameter logic [7:0] START_CHAR = 8'hDF,
  parameter logic [7:0] TERM_CHAR  = 8'hBF,
  parameter logic [7:0] SFD_CHAR   = 8'hD5,
  parameter int         MIN_FRAME  = 64
) (
  input logic              rxclk,
  input logic              reset_n,
  rx_frame_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME} state_t;

  localparam logic [15:0] MIN16 = 16'(MIN_FRAME);

  state_t      state, state_nxt;
  logic [7:0]  lane [LANES];
  logic        start_hit;
  logic        upper_ctrl;

  logic        sof_n, eof_n, perr_n, abort, scan_en;
  logic        found, cerr;
  logic [2:0]  tl;
  logic [3:0]  ndata;
  logic [16:0] pos, sum;
  logic [2:0]  sidx;
  logic [15:0] cnt_n, lt_n;
  logic [47:0] da_n, sa_n;
  logic        tag_n, pause_n;

  logic        sof_q, eof_q, perr_q;
  logic [15:0] count_q, lt_q;
  logic [47:0] da_q, sa_q;
  logic        err_q, ferr_q, short_q;
  logic        tag_q, pause_q;
  logic [2:0]  term_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane[i] = bus.rxd[8*i +: 8];
    end
  end

  assign start_hit  = bus.rxc[0] && (lane[0] == START_CHAR);
  assign upper_ctrl = |bus.rxc[LANES-1:1];

  always_comb begin
    state_nxt = state;
    sof_n     = 1'b0;
    eof_n     = 1'b0;
    perr_n    = 1'b0;
    abort     = 1'b0;
    scan_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_hit) begin
          if (LANES == 8) begin
            if (!upper_ctrl && lane[LANES-1] == SFD_CHAR) begin
              state_nxt = FRAME;
              sof_n     = 1'b1;
            end else begin
              perr_n = 1'b1;
            end
          end else if (!upper_ctrl) begin
            state_nxt = PRE;
          end else begin
            perr_n = 1'b1;
          end
        end
      end
      PRE: begin
        if (bus.rxc == '0 && lane[LANES-1] == SFD_CHAR) begin
          state_nxt = FRAME;
          sof_n     = 1'b1;
        end else begin
          state_nxt = IDLE;
          perr_n    = 1'b1;
        end
      end
      FRAME: begin
        // an aborting start is consumed here, never reparsed as a start
        if (start_hit) begin
          abort     = 1'b1;
          eof_n     = 1'b1;
          state_nxt = IDLE;
        end else begin
          scan_en = 1'b1;
          if (found) begin
            eof_n     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    found = 1'b0;
    cerr  = 1'b0;
    tl    = '0;
    ndata = '0;
    pos   = '0;
    sidx  = '0;
    da_n  = da_q;
    sa_n  = sa_q;
    lt_n  = lt_q;
    for (int i = 0; i < LANES; i++) begin
      if (!found) begin
        if (bus.rxc[i]) begin
          if (lane[i] == TERM_CHAR) begin
            found = 1'b1;
            tl    = 3'(i);
          end else begin
            cerr = 1'b1;
          end
        end else begin
          pos = {1'b0, count_q} + 17'(ndata);
          if (scan_en) begin
            if (pos < 17'd6) begin
              da_n[{pos[2:0], 3'b000} +: 8] = lane[i];
            end else if (pos < 17'd12) begin
              sidx = 3'(pos - 17'd6);
              sa_n[{sidx, 3'b000} +: 8] = lane[i];
            end else if (pos == 17'd12) begin
              lt_n[15:8] = lane[i];
            end else if (pos == 17'd13) begin
              lt_n[7:0] = lane[i];
            end
          end
          ndata = ndata + 4'd1;
        end
      end
    end
  end

  assign sum     = {1'b0, count_q} + 17'(ndata);
  assign cnt_n   = !scan_en ? count_q :
                   sum[16]  ? 16'hFFFF : sum[15:0];
  assign tag_n   = (lt_n == 16'h8100);
  assign pause_n = (lt_n == 16'h8808);

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      perr_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      da_q    <= '0;
      sa_q    <= '0;
      lt_q    <= '0;
      ferr_q  <= 1'b0;
      short_q <= 1'b0;
      tag_q   <= 1'b0;
      pause_q <= 1'b0;
      term_q  <= '0;
    end else begin
      state  <= state_nxt;
      sof_q  <= sof_n;
      eof_q  <= eof_n;
      perr_q <= perr_n;
      if (sof_n) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (scan_en) begin
        count_q <= cnt_n;
        err_q   <= err_q | cerr;
        da_q    <= da_n;
        sa_q    <= sa_n;
        lt_q    <= lt_n;
      end
      if (eof_n) begin
        ferr_q  <= abort | err_q | cerr;
        term_q  <= abort ? 3'd0 : tl;
        short_q <= (cnt_n < MIN16);
        tag_q   <= tag_n;
        pause_q <= pause_n;
      end
    end
  end

`ifdef RX_LEN_CHECK_EN
  logic signed [16:0] pay, ltv;
  logic               lerr_q;

  always_comb begin
    pay = $signed({1'b0, cnt_n}) - 17'sd18
        - (tag_n ? 17'sd4 : 17'sd0);
    ltv = $signed({1'b0, lt_n});
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      lerr_q <= 1'b0;
    end else if (eof_n) begin
      lerr_q <= (lt_n <= 16'd1500) && (ltv > pay);
    end
  end

  assign bus.length_error = lerr_q;
`else
  assign bus.length_error = 1'b0;
`endif

  assign bus.sof          = sof_q;
  assign bus.eof          = eof_q;
  assign bus.preamble_err = perr_q;
  assign bus.da_addr      = da_q;
  assign bus.sa_addr      = sa_q;
  assign bus.lt_data      = lt_q;
  assign bus.tagged_frame = tag_q;
  assign bus.pause_frame  = pause_q;
  assign bus.byte_count   = count_q;
  assign bus.term_lane    = term_q;
  assign bus.frame_error  = ferr_q;
  assign bus.short_frame  = short_q;

endmodule
